// File: rtl/alu_pkg.sv
// Shared ALU-side definitions: divider state encoding and stall latency.
// SEQ_DIVIDER_SIGNED_EN (see seq_divider.sv) does not change anything here.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam int DIV_WIDTH   = 32;
  // Cycles from the accepting edge of start to the done cycle.
  localparam int DIV_LATENCY = DIV_WIDTH + 2;

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between the execute stage (master) and the divider (slave).
// start is a one-cycle request taken only while the divider is idle; busy covers the
// whole operation, done is a one-cycle pulse and the results stay put until the next request.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/ripple_subtractor.sv
// Combinational a - b from full-adder cells: a + ~b + 1, borrow is the inverted carry out.
module ripple_subtractor #(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  logic carry;

  always_comb begin
    carry = 1'b1;
    diff  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      diff[i] = a[i] ^ ~b[i] ^ carry;
      carry   = (a[i] & ~b[i]) | (a[i] & carry) | (~b[i] & carry);
    end
    borrow = ~carry;
  end

endmodule

// File: rtl/seq_divider.sv
// Restoring radix-2 divider, one quotient bit per clock, RISC-V DIV/DIVU/REM/REMU results.
// Define SEQ_DIVIDER_SIGNED_EN to honour signed_op; otherwise every operation is unsigned.
module seq_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  bus,
  output div_state_t    state
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] dvd_raw;
  logic [WIDTH-1:0] dvs_raw;

  logic [WIDTH-1:0] dvd_mag_in;
  logic [WIDTH-1:0] dvs_mag_in;
  logic [WIDTH:0]   partial;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic             dbz_fix;

`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  logic op_signed;
  logic neg_q;
  logic neg_r;
`else
  wire unused_signed_op = bus.signed_op;
`endif

  always_comb begin
    dvd_mag_in = bus.dividend;
    dvs_mag_in = bus.divisor;
`ifdef SEQ_DIVIDER_SIGNED_EN
    if (bus.signed_op && bus.dividend[WIDTH-1]) dvd_mag_in = -bus.dividend;
    if (bus.signed_op && bus.divisor[WIDTH-1])  dvs_mag_in = -bus.divisor;
`endif
  end

  // The partial remainder is always below the divisor, so the difference fits WIDTH bits.
  assign partial = {rem, quo[WIDTH-1]};

  ripple_subtractor #(.WIDTH(WIDTH + 1)) u_sub (
    .a      (partial),
    .b      ({1'b0, dvs_mag}),
    .diff   (diff),
    .borrow (borrow)
  );

  wire unused_diff_msb = diff[WIDTH];

  always_comb begin
    q_fix   = quo;
    r_fix   = rem;
    dbz_fix = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
    if (neg_q) q_fix = -quo;
    if (neg_r) r_fix = -rem;
    if (op_signed && dvd_raw == MIN_NEG && dvs_raw == '1) begin
      q_fix = dvd_raw;
      r_fix = '0;
    end
`endif
    if (dvs_raw == '0) begin
      q_fix   = '1;
      r_fix   = dvd_raw;
      dbz_fix = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      count           <= '0;
      rem             <= '0;
      quo             <= '0;
      dvs_mag         <= '0;
      dvd_raw         <= '0;
      dvs_raw         <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      op_signed       <= 1'b0;
      neg_q           <= 1'b0;
      neg_r           <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            count    <= '0;
            rem      <= '0;
            quo      <= dvd_mag_in;
            dvs_mag  <= dvs_mag_in;
            dvd_raw  <= bus.dividend;
            dvs_raw  <= bus.divisor;
            bus.busy <= 1'b1;
            state    <= CALC;
`ifdef SEQ_DIVIDER_SIGNED_EN
            op_signed <= bus.signed_op;
            neg_q     <= bus.signed_op & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            neg_r     <= bus.signed_op & bus.dividend[WIDTH-1];
`endif
          end
        end
        CALC: begin
          rem   <= borrow ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
          quo   <= {quo[WIDTH-2:0], ~borrow};
          count <= count + CW'(1);
          if (count == LAST) state <= FIX;
        end
        FIX: begin
          bus.quotient    <= q_fix;
          bus.remainder   <= r_fix;
          bus.div_by_zero <= dbz_fix;
          state           <= DONE;
        end
        DONE: begin
          // First DONE cycle raises done, second retires it; start stays ignored throughout.
          if (!bus.done) begin
            bus.done <= 1'b1;
          end else begin
            bus.done <= 1'b0;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vector table, handshake corner cases,
// and randomized operations against an arithmetic reference model.
module tb_seq_divider;
  import alu_pkg::*;

  localparam int W = 32;
`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  div_state_t state;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .state (state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: plain division with the RISC-V special cases.
  task automatic ref_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic dbz);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    logic                signed_mode;
    sa = a;
    sb = b;
    signed_mode = sgn & SIGNED_EN;
    dbz = 1'b0;
    if (b == 0) begin
      q = '1; r = a; dbz = 1'b1;
    end else if (signed_mode && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = '0;
    end else if (signed_mode) begin
      q = sa / sb; r = sa % sb;
    end else begin
      q = a / b; r = a % b;
    end
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end at a point 1 time unit after a rising edge.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic dbz, output int lat);
    bus.start     = 1'b1;
    bus.signed_op = sgn;
    bus.dividend  = a;
    bus.divisor   = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(lat);
    q   = bus.quotient;
    r   = bus.remainder;
    dbz = bus.div_by_zero;
  endtask

  typedef struct {
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [W-1:0] q, r, eq, er, a, b;
    logic         dbz, edbz, sgn;
    int           lat, seen;

    vecs.push_back('{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0});
    vecs.push_back('{1'b1, 32'hFFFF_FF9C, 32'd7,
                     SIGNED_EN ? 32'hFFFF_FFF2 : 32'h2492_4916,
                     SIGNED_EN ? 32'hFFFF_FFFE : 32'h0000_0002, 1'b0});
    vecs.push_back('{1'b0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1});
    vecs.push_back('{1'b1, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1});
    vecs.push_back('{1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
                     SIGNED_EN ? 32'h8000_0000 : 32'h0,
                     SIGNED_EN ? 32'h0 : 32'h8000_0000, 1'b0});
    vecs.push_back('{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0});
    vecs.push_back('{1'b1, 32'd100, 32'hFFFF_FFF9,
                     SIGNED_EN ? 32'hFFFF_FFF2 : 32'h0,
                     SIGNED_EN ? 32'd2 : 32'd100, 1'b0});
    vecs.push_back('{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9,
                     SIGNED_EN ? 32'd14 : 32'h0,
                     SIGNED_EN ? 32'hFFFF_FFFE : 32'hFFFF_FF9C, 1'b0});
    vecs.push_back('{1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0});
    vecs.push_back('{1'b0, 32'd7, 32'd100, 32'd0, 32'd7, 1'b0});
    vecs.push_back('{1'b0, 32'd0, 32'd5, 32'd0, 32'd0, 1'b0});
    vecs.push_back('{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0});
    vecs.push_back('{1'b1, 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0});

    rst = 1'b1;
    bus.start = 1'b0; bus.signed_op = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", W'(bus.busy), 0);
    check("reset_done", W'(bus.done), 0);
    check("reset_quotient", bus.quotient, 0);
    check("reset_remainder", bus.remainder, 0);
    check("reset_dbz", W'(bus.div_by_zero), 0);
    check("reset_state", W'(state), W'(IDLE));
    rst = 1'b0;
    @(posedge clk); #1;

    // ---------------- directed table ----------------
    foreach (vecs[i]) begin
      run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, q, r, dbz, lat);
      check($sformatf("vec%0d_quotient", i), q, vecs[i].q);
      check($sformatf("vec%0d_remainder", i), r, vecs[i].r);
      check($sformatf("vec%0d_dbz", i), W'(dbz), W'(vecs[i].dbz));
      check($sformatf("vec%0d_latency", i), W'(lat), W'(DIV_LATENCY));
      check($sformatf("vec%0d_busy_at_done", i), W'(bus.busy), 1);
      @(posedge clk); #1;
      check($sformatf("vec%0d_busy_after", i), W'(bus.busy), 0);
      check($sformatf("vec%0d_done_pulse", i), W'(bus.done), 0);
    end

    // ---------------- start pulsed mid-operation ----------------
    bus.start = 1'b1; bus.signed_op = 1'b0; bus.dividend = 32'd100; bus.divisor = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 100) begin
      if (lat == 10) begin
        bus.start = 1'b1; bus.dividend = 32'd5; bus.divisor = 32'd1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    check("midstart_latency", W'(lat), W'(DIV_LATENCY));
    check("midstart_quotient", bus.quotient, 32'd14);
    check("midstart_remainder", bus.remainder, 32'd2);

    // ---------------- start during done, then back-to-back ----------------
    bus.start = 1'b1; bus.dividend = 32'd1000; bus.divisor = 32'd10;
    @(posedge clk); #1;
    check("done_cycle_start_ignored", W'(bus.busy), 0);
    check("done_cycle_done_low", W'(bus.done), 0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("b2b_accepted_busy", W'(bus.busy), 1);
    wait_done(lat);
    check("b2b_latency", W'(lat), W'(DIV_LATENCY));
    check("b2b_quotient", bus.quotient, 32'd100);
    check("b2b_remainder", bus.remainder, 32'd0);
    @(posedge clk); #1;

    // ---------------- reset mid-CALC ----------------
    bus.start = 1'b1; bus.signed_op = 1'b0; bus.dividend = 32'hDEAD_BEEF; bus.divisor = 32'h1234;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_busy", W'(bus.busy), 0);
    check("abort_done", W'(bus.done), 0);
    check("abort_quotient", bus.quotient, 0);
    check("abort_remainder", bus.remainder, 0);
    check("abort_state", W'(state), W'(IDLE));
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) seen++;
    end
    check("abort_no_done", W'(seen), 0);
    run_op(1'b1, 32'hFFFF_FF9C, 32'd7, q, r, dbz, lat);
    ref_div(1'b1, 32'hFFFF_FF9C, 32'd7, eq, er, edbz);
    check("after_abort_quotient", q, eq);
    check("after_abort_remainder", r, er);
    check("after_abort_latency", W'(lat), W'(DIV_LATENCY));
    @(posedge clk); #1;

    // ---------------- randomized against the model ----------------
    for (int n = 0; n < 40; n++) begin
      sgn = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 300)) : W'($urandom);
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = W'($urandom_range(1, 15));
        2: b = '1;
        3: begin a = 32'h8000_0000; b = '1; end
        default: b = W'($urandom);
      endcase
      ref_div(sgn, a, b, eq, er, edbz);
      exp_q.push_back(eq);
      exp_q.push_back(er);
      run_op(sgn, a, b, q, r, dbz, lat);
      check($sformatf("rnd%0d_quotient", n), q, exp_q.pop_front());
      check($sformatf("rnd%0d_remainder", n), r, exp_q.pop_front());
      check($sformatf("rnd%0d_dbz", n), W'(dbz), W'(edbz));
      check($sformatf("rnd%0d_latency", n), W'(lat), W'(DIV_LATENCY));
      @(posedge clk); #1;
    end

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
